seq_mult_unit: RTL and testbench
================================

Name: seq_mult_unit

Overview:
- Iterative unsigned integer multiplier: radix-2 shift-and-add, one multiplier bit per clock.
- Computes P = A × B, where A and B are INPUT_SIZE bits and P is 2×INPUT_SIZE bits.
- Supplies mantissa products to the floating-point multiplier path, mirroring the existing shift-subtract divide path.
- Operands load on a start/busy/done handshake; the product is held until the next operation.

Parameters:
- INPUT_SIZE, 10, operand width in bits; product width is 2×INPUT_SIZE; minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new multiply; sampled only when busy=0.
- A  input  INPUT_SIZE  multiplicand; captured on the accepting edge.
- B  input  INPUT_SIZE  multiplier; captured on the accepting edge.
- P  output  2*INPUT_SIZE  product, registered; valid while done=1 and held afterwards.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking P valid.

Behaviour:
- Reset: rst=1 at a rising edge puts the block in IDLE with P=0, busy=0, done=0, and all internal registers cleared. rst has priority over every other input.
- Reset mid-operation aborts the operation; no done pulse is issued for it.
- States:
  - IDLE: waiting for start.
  - RUN: iterating.
  - DONE: one cycle, asserts done.
- Transitions:
  - IDLE→RUN on start=1.
  - RUN→DONE on the final iteration edge.
  - DONE→RUN if start=1, otherwise DONE→IDLE.
- busy=1 exactly when the state is RUN; done=1 exactly when the state is DONE.
- Accept: start is accepted at edge t0 when busy=0 (state IDLE or DONE). On accept:
  - M ← A and hi ← 0, where hi is INPUT_SIZE+1 bits wide to hold the carry.
  - lo ← B.
  - Iteration counter ← INPUT_SIZE.
- start while busy=1 is ignored: no queueing, and operands are not re-captured.
- Iteration on each RUN edge:
  - If lo[0]=1, then hi ← hi + M; otherwise hi is unchanged.
  - Then {hi,lo} shifts right by 1 with zero fill.
  - The counter decrements by 1.
- The final iteration is the one where the counter goes from 1 to 0. On that edge, P ← the low 2×INPUT_SIZE bits of {hi,lo}, and the state goes to DONE.
- Latency: iterations occur on edges t0+1 through t0+INPUT_SIZE. done is first sampled high at edge t0+INPUT_SIZE+1, for exactly one cycle.
- Back-to-back: start=1 while in DONE is accepted on that same edge, giving a throughput of one result per INPUT_SIZE+1 cycles.
- P changes only at the final-iteration edge or on reset. Between operations it holds the last result, including during the next RUN.
- Arithmetic is exact unsigned with no overflow: the maximum product, (2^N−1)^2, fits in 2N bits.
- Zero operands take full latency in the base build (no special case).

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- When defined:
  - On each RUN edge, after performing that edge's iteration, the block checks the unprocessed multiplier bits (the low `counter−1` bits of the shifted lo).
  - If those bits are all zero, that edge is treated as final: P ← ({hi,lo} after shift) >> (counter−1), and the state goes to DONE.
  - Resulting latency: done is sampled high at edge t0+k+2, where k is the index of the most significant set bit of B. For B=0 or B=1, done is at t0+2.
  - Results are bit-identical to the base build.
- When not defined: fixed latency of INPUT_SIZE+1 cycles and no early-check logic.

Test Plan:
1. INPUT_SIZE=10; A=5, B=3, start pulse at t0 → busy=1 for 10 cycles; done sampled high at t0+11 for 1 cycle; P=15; P still 15 ten cycles later.
2. A=1023, B=1023 → P=1046529 (20'hFF801), done at t0+11. A=1023, B=0 → P=0; done at t0+11 in the base build, at t0+2 with SEQ_MULT_EARLY_TERM_EN.
3. start held high continuously with operand pairs (7,9) then (512,2), presented to be captured at successive accepts → P=63, then P=1024; accepts are 11 edges apart; each done lasts one cycle; operand changes while busy=1 do not affect the results.
4. Assert start at t0+3 of an active operation with A=0, B=0 → ignored; the original product still completes at t0+11; no extra done pulse.
5. Assert rst=1 at t0+5 mid-operation → next cycle state is IDLE, P=0, busy=0, done=0; no done pulse; the next start (A=2, B=6) yields P=12 at normal latency.
6. With SEQ_MULT_EARLY_TERM_EN, A=3, B=0b0000010000 (k=4) → P=48, done at t0+6. Random sweep of 1000 operand pairs checked against a reference model in both builds.

Source files
------------

// File: rtl/seq_mult_unit.sv
// Radix-2 shift-and-add unsigned multiplier: one multiplier bit per clock, start/busy/done handshake.
// Optional SEQ_MULT_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are all zero.
module seq_mult_unit #(
  parameter int INPUT_SIZE = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [INPUT_SIZE-1:0]     A,
  input  logic [INPUT_SIZE-1:0]     B,
  output logic [2*INPUT_SIZE-1:0]   P,
  output logic                      busy,
  output logic                      done
);

  localparam int N  = INPUT_SIZE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state;
  logic [N-1:0]  m;
  logic [N:0]    hi;
  logic [N-1:0]  lo;
  logic [CW-1:0] cnt;

  logic [N:0]     sum;
  logic [2*N:0]   shifted;
  logic [N:0]     hi_nxt;
  logic [N-1:0]   lo_nxt;
  logic [2*N-1:0] prod;
  logic           last;

  // hi is one bit wider than M so the add can never lose its carry.
  always_comb begin
    sum     = lo[0] ? hi + {1'b0, m} : hi;
    shifted = {sum, lo} >> 1;
    hi_nxt  = shifted[2*N:N];
    lo_nxt  = shifted[N-1:0];
  end

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic [N-1:0] rem_mask;

  // Once the unprocessed multiplier bits are zero, the remaining edges would only shift.
  always_comb begin
    rem_mask = '0;
    for (int i = 0; i < N; i++) begin
      rem_mask[i] = (i < int'(cnt) - 1);
    end
    last = ~|(lo_nxt & rem_mask);
    prod = (2*N)'(shifted >> (cnt - CW'(1)));
  end
`else
  always_comb begin
    last = (cnt == CW'(1));
    prod = shifted[2*N-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      m     <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      P     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            m     <= A;
            hi    <= '0;
            lo    <= B;
            cnt   <= CW'(N);
            state <= S_RUN;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt - CW'(1);
          if (last) begin
            P     <= prod;
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_unit.sv
// Scoreboard bench for seq_mult_unit: driver pushes expected product and done cycle, monitor checks on done.
module tb_seq_mult_unit;

  localparam int     N    = 10;
  localparam longint MAXV = (longint'(1) << N) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   A = '0;
  logic [N-1:0]   B = '0;
  logic [2*N-1:0] P;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  seq_mult_unit #(.INPUT_SIZE(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .P(P), .busy(busy), .done(done)
  );

  typedef struct {
    longint p;
    longint due;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Cycles from accepting edge to the edge at which done is first sampled high.
  function automatic longint ref_lat(input longint b);
`ifdef SEQ_MULT_EARLY_TERM_EN
    longint v = b;
    longint k = 0;
    if (b <= 1) return 2;
    while (v > 1) begin
      v = v / 2;
      k++;
    end
    return k + 2;
`else
    return b * 0 + N + 1;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      chk("done_pulse_width", prev_done, 0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: P=%0d with no operation outstanding (cycle %0d)", P, cyc);
      end else begin
        e = sb.pop_front();
        chk("product", P, e.p);
        chk("done_cycle", cyc, e.due);
      end
    end
    prev_done = done;
  end

  task automatic do_op(input longint a, input longint b, input bit hold, output longint t0);
    int guard = 0;
    start = 1'b1;
    A = a[N-1:0];
    B = b[N-1:0];
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_wait: busy stuck high, got busy=%0d, expected 0", busy);
    end
    @(posedge clk);
    #1;
    t0 = cyc;
    // done is sampled at edge t0+lat, i.e. it is visible in the cycle after edge t0+lat-1
    sb.push_back('{p: a * b, due: t0 + ref_lat(b) - 1});
    if (!hold) start = 1'b0;
    A = N'($urandom);
    B = N'($urandom);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((sb.size() != 0 || busy || done) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_outstanding", sb.size(), 0);
  endtask

  function automatic longint pick();
    int r = $urandom_range(0, 7);
    if (r == 0) return 0;
    if (r == 1) return MAXV;
    if (r == 2) return 1;
    return longint'($urandom_range(0, 32'(MAXV)));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    longint t0, t1, t2, a, b;
    int     bc, g;
    bit     hold;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_P", P, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    // 5*3: busy length, product, and hold afterwards
    do_op(5, 3, 0, t0);
    bc = 0;
    g  = 0;
    while (!done && g < 100) begin
      @(negedge clk);
      if (busy) bc++;
      g++;
    end
    chk("busy_cycles", bc, ref_lat(3) - 1);
    repeat (10) @(negedge clk);
    chk("P_held", P, 15);
    chk("idle_busy", busy, 0);

    do_op(MAXV, MAXV, 0, t0);
    wait_idle();
    chk("max_product", P, 20'hFF801);
    do_op(MAXV, 0, 0, t0);
    wait_idle();

    // start held high: second pair accepted on the DONE edge
    do_op(7, 9, 1, t1);
    do_op(512, 2, 0, t2);
    chk("b2b_spacing", t2 - t1, ref_lat(9));
    wait_idle();
    chk("b2b_last_P", P, 1024);

    // start during RUN must be ignored
    do_op(5, 600, 0, t0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    A = '0;
    B = '0;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("ignored_start_P", P, 3000);

    // reset mid-operation aborts with no done
    do_op(9, 1000, 0, t0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    chk("abort_P", P, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (12) @(negedge clk);
    do_op(2, 6, 0, t0);
    wait_idle();
    chk("after_abort_P", P, 12);

    do_op(3, 16, 0, t0);
    wait_idle();

    for (int i = 0; i < 1000; i++) begin
      a = pick();
      b = pick();
      hold = (i != 999) && ($urandom_range(0, 1) == 1);
      do_op(a, b, hold, t0);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
